// File: rtl/dsm_cfg_pkg.sv
// dsm_cfg_pkg -- shared definitions for the serial configuration block.
//   state_t         : frame FSM states (IDLE, SHIFT, HOLD)
//   DEF_DATA_W      : default register word width
//   DEF_ADDR_W      : default address field width
//   DEF_NUM_REGS    : default register count
package dsm_cfg_pkg;

  localparam int DEF_DATA_W   = 9;
  localparam int DEF_ADDR_W   = 2;
  localparam int DEF_NUM_REGS = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/dsm_sipo_n.sv
// dsm_sipo_n -- serial-in / parallel-out shift register, MSB first.
// Ports:
//   sclk : clock, posedge
//   rst  : asynchronous active-high reset, clears the register
//   en   : shift enable
//   din  : serial bit, enters at bit 0
//   q    : parallel contents, oldest bit at WIDTH-1
module dsm_sipo_n #(
  parameter int WIDTH = 8
) (
  input  logic             sclk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  generate
    if (WIDTH == 1) begin : g_one
      always_ff @(posedge sclk or posedge rst) begin
        if (rst)     q <= '0;
        else if (en) q <= din;
      end
    end else begin : g_many
      always_ff @(posedge sclk or posedge rst) begin
        if (rst)     q <= '0;
        else if (en) q <= {q[WIDTH-2:0], din};
      end
    end
  endgenerate

endmodule

// File: rtl/dsm_serial_cfg.sv
// dsm_serial_cfg -- serial configuration port with shadow/active banks.
// A frame is ADDR_W address bits followed by DATA_W data bits, MSB first,
// framed by cs_n low. A complete frame writes the shadow bank; upd copies
// the whole shadow bank into the active bank driven on cfg_out.
// Optional feature: define DSM_SCFG_READBACK_EN to return active[addr]
// on sdo during the data phase; otherwise sdo is tied to 0.
// Ports:
//   sclk      : clock, all logic on posedge
//   rst       : asynchronous active-high reset
//   cs_n      : frame select, active-low
//   sdata     : serial data in, MSB first
//   upd       : commit shadow bank to active bank
//   err_clr   : clear frame_err
//   cfg_out   : active bank, register k at [k*DATA_W +: DATA_W]
//   busy      : FSM not idle
//   frame_err : sticky frame error (short, overlong or bad address)
//   sdo       : readback serial data out
module dsm_serial_cfg
  import dsm_cfg_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_REGS = DEF_NUM_REGS
) (
  input  logic                       sclk,
  input  logic                       rst,
  input  logic                       cs_n,
  input  logic                       sdata,
  input  logic                       upd,
  input  logic                       err_clr,
  output logic [NUM_REGS*DATA_W-1:0] cfg_out,
  output logic                       busy,
  output logic                       frame_err,
  output logic                       sdo
);

  localparam int FRAME_W = ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FRAME_W);
  localparam logic [ADDR_W:0]   REGS_LIM = (ADDR_W + 1)'(NUM_REGS);

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt, cnt_inc;
  logic                shift_en, frame_done, err_set, addr_ok, wr_en;
  logic [FRAME_W-2:0]  sr_q;
  logic [FRAME_W-1:0]  word_nxt;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic [DATA_W-1:0]   shadow [NUM_REGS];
  logic [DATA_W-1:0]   active [NUM_REGS];

  // Only FRAME_W-1 bits are stored: the last bit is used straight from
  // sdata on the capturing edge, so the write happens on that same edge.
  dsm_sipo_n #(.WIDTH(FRAME_W - 1)) u_sipo (
    .sclk (sclk),
    .rst  (rst),
    .en   (shift_en),
    .din  (sdata),
    .q    (sr_q)
  );

  assign word_nxt = {sr_q, sdata};
  assign wr_addr  = word_nxt[FRAME_W-1 -: ADDR_W];
  assign wr_data  = word_nxt[DATA_W-1:0];
  assign cnt_inc  = (cnt == CNT_LAST) ? cnt : cnt + 1'b1;
  assign busy     = (state != ST_IDLE);

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    shift_en   = 1'b0;
    frame_done = 1'b0;
    err_set    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!cs_n) begin
          shift_en  = 1'b1;
          cnt_nxt   = CNT_W'(1);
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cs_n) begin
          err_set   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = ST_IDLE;
        end else begin
          shift_en = 1'b1;
          cnt_nxt  = cnt_inc;
          if (cnt_inc == CNT_LAST) begin
            frame_done = 1'b1;
            state_nxt  = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        // Extra bits are not shifted, so the written word stays intact.
        if (cs_n) begin
          cnt_nxt   = '0;
          state_nxt = ST_IDLE;
        end else begin
          err_set = 1'b1;
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = ST_IDLE;
      end
    endcase
    addr_ok = ({1'b0, wr_addr} < REGS_LIM);
    wr_en   = frame_done & addr_ok;
    if (frame_done && !addr_ok) err_set = 1'b1;
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      frame_err <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      // A new error on the same edge as err_clr keeps the flag set.
      if (err_set)      frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;
    end
  end

  // Nonblocking update: a commit on the write edge picks up the old shadow.
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        shadow[k] <= '0;
        active[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (upd) active[k] <= shadow[k];
        if (wr_en && (wr_addr == ADDR_W'(k))) shadow[k] <= wr_data;
      end
    end
  end

  generate
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
      assign cfg_out[g*DATA_W +: DATA_W] = active[g];
    end
  endgenerate

`ifdef DSM_SCFG_READBACK_EN
  localparam logic [CNT_W-1:0] CNT_ADDR = CNT_W'(ADDR_W);

  logic                addr_edge;
  logic [ADDR_W-1:0]   rb_addr;
  logic [DATA_W-1:0]   rb_word, rb_sr;

  always_comb begin
    rb_addr   = word_nxt[ADDR_W-1:0];
    addr_edge = shift_en && (cnt_nxt == CNT_ADDR);
    rb_word   = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (rb_addr == ADDR_W'(k)) rb_word = active[k];
    end
  end

  // rb_sr holds the bits still to be sent; it is zero outside a readback,
  // so address-phase shifts and out-of-range addresses leave sdo at 0.
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      sdo   <= 1'b0;
      rb_sr <= '0;
    end else if (addr_edge) begin
      sdo   <= rb_word[DATA_W-1];
      rb_sr <= rb_word << 1;
    end else if (shift_en && (state == ST_SHIFT)) begin
      sdo   <= rb_sr[DATA_W-1];
      rb_sr <= rb_sr << 1;
    end else begin
      sdo   <= 1'b0;
      rb_sr <= '0;
    end
  end
`else
  assign sdo = 1'b0;
`endif

endmodule

// File: tb/tb_dsm_serial_cfg.sv
// tb_dsm_serial_cfg -- randomized bench for dsm_serial_cfg with a
// frame-level reference model (shadow/active arrays and an error flag).
// NUM_REGS is set below 2**ADDR_W so out-of-range addresses occur.
module tb_dsm_serial_cfg;

  localparam int DATA_W   = 9;
  localparam int ADDR_W   = 2;
  localparam int NUM_REGS = 3;
  localparam int FRAME_W  = ADDR_W + DATA_W;
  localparam int NSLOT    = 2 ** ADDR_W;
`ifdef DSM_SCFG_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic sclk = 1'b0;
  logic rst = 1'b0;
  logic cs_n = 1'b1;
  logic sdata = 1'b0;
  logic upd = 1'b0;
  logic err_clr = 1'b0;
  logic [NUM_REGS*DATA_W-1:0] cfg_out;
  logic busy, frame_err, sdo;

  dsm_serial_cfg #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) dut (
    .sclk      (sclk),
    .rst       (rst),
    .cs_n      (cs_n),
    .sdata     (sdata),
    .upd       (upd),
    .err_clr   (err_clr),
    .cfg_out   (cfg_out),
    .busy      (busy),
    .frame_err (frame_err),
    .sdo       (sdo)
  );

  always #5 sclk = ~sclk;

  int n_vec = 0;
  int n_bad = 0;

  logic [DATA_W-1:0] m_shd [NSLOT];
  logic [DATA_W-1:0] m_act [NSLOT];
  bit                m_err;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NUM_REGS*DATA_W-1:0] exp_cfg();
    logic [NUM_REGS*DATA_W-1:0] v;
    for (int k = 0; k < NUM_REGS; k++) v[k*DATA_W +: DATA_W] = m_act[k];
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NSLOT; k++) begin
      m_shd[k] = '0;
      m_act[k] = '0;
    end
    m_err = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".cfg"}, cfg_out, exp_cfg());
    chk({tag, ".err"}, frame_err, m_err);
    chk({tag, ".busy"}, busy, 1'b0);
    chk({tag, ".sdo"}, sdo, 1'b0);
  endtask

  // Sends nbits of a frame (short, exact or overlong), optionally with upd on
  // the last frame bit and err_clr on the cs_n-high edge, then updates the model.
  task automatic send_frame(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                            input int nbits, input bit upd_last, input bit clr_end);
    logic [FRAME_W-1:0] w;
    logic [DATA_W-1:0]  rbw;
    bit                 inr, exp_sdo;
    int                 j;
    w   = {a, d};
    inr = (int'(a) < NUM_REGS);
    rbw = inr ? m_act[a] : '0;
    for (int i = 0; i < nbits; i++) begin
      @(negedge sclk);
      cs_n  = 1'b0;
      sdata = (i < FRAME_W) ? w[FRAME_W-1-i] : 1'($urandom);
      upd   = (i == FRAME_W - 1) && upd_last;
      @(posedge sclk);
      #1;
      j = i - (ADDR_W - 1);
      exp_sdo = RB && (j >= 0) && (j < DATA_W) && rbw[DATA_W-1-j];
      chk("bit.busy", busy, 1'b1);
      chk("bit.sdo", sdo, exp_sdo);
    end
    @(negedge sclk);
    cs_n    = 1'b1;
    upd     = 1'b0;
    err_clr = clr_end;
    @(posedge sclk);
    #1;
    if (nbits >= FRAME_W) begin
      if (upd_last) for (int k = 0; k < NSLOT; k++) m_act[k] = m_shd[k];
      if (inr) m_shd[a] = d;
      else     m_err = 1'b1;
      if (nbits > FRAME_W) m_err = 1'b1;
      if (clr_end) m_err = 1'b0;
    end else begin
      m_err = 1'b1;
    end
    check_idle("frame");
    @(negedge sclk);
    err_clr = 1'b0;
  endtask

  task automatic do_upd();
    @(negedge sclk);
    upd = 1'b1;
    @(posedge sclk);
    #1;
    for (int k = 0; k < NSLOT; k++) m_act[k] = m_shd[k];
    chk("upd.cfg", cfg_out, exp_cfg());
    @(negedge sclk);
    upd = 1'b0;
  endtask

  task automatic do_clr();
    @(negedge sclk);
    err_clr = 1'b1;
    @(posedge sclk);
    #1;
    m_err = 1'b0;
    chk("clr.err", frame_err, m_err);
    @(negedge sclk);
    err_clr = 1'b0;
  endtask

  initial begin
    logic [FRAME_W-1:0] w;
    logic [ADDR_W-1:0]  ra;
    logic [DATA_W-1:0]  rd;
    int                 sel, nb;
    bit                 ul, ce;

    model_reset();
    #1 rst = 1'b1;
    #11;
    check_idle("reset");
    @(negedge sclk);
    rst = 1'b0;

    // Basic write and commit.
    send_frame(2'd1, 9'h1A5, FRAME_W, 1'b0, 1'b0);
    do_upd();
    chk("r1.basic", cfg_out[DATA_W +: DATA_W], 9'h1A5);

    // Short frame: no write, error set, then cleared.
    send_frame(2'd2, 9'h0AA, 6, 1'b0, 1'b0);
    chk("short.err", frame_err, 1'b1);
    do_upd();
    do_clr();

    // Overlong frame still writes the word.
    send_frame(2'd2, 9'h0FF, 13, 1'b0, 1'b0);
    chk("long.err", frame_err, 1'b1);
    do_upd();
    chk("r2.long", cfg_out[2*DATA_W +: DATA_W], 9'h0FF);
    do_clr();

    // Commit on the write edge sees the old shadow value.
    send_frame(2'd1, 9'h033, FRAME_W, 1'b1, 1'b0);
    chk("r1.same_edge", cfg_out[DATA_W +: DATA_W], 9'h1A5);
    do_upd();
    chk("r1.next_upd", cfg_out[DATA_W +: DATA_W], 9'h033);

    // Error on the same edge as err_clr wins; clean frame with clear clears.
    send_frame(2'd0, 9'h111, 4, 1'b0, 1'b1);
    chk("clr_vs_err", frame_err, 1'b1);
    send_frame(2'd0, 9'h122, FRAME_W, 1'b0, 1'b1);

    // Out-of-range address.
    send_frame(2'd3, 9'h1FF, FRAME_W, 1'b0, 1'b0);
    do_upd();
    do_clr();

    // Reset in the middle of a frame.
    w = {2'd2, 9'h0C3};
    for (int i = 0; i < 5; i++) begin
      @(negedge sclk);
      cs_n  = 1'b0;
      sdata = w[FRAME_W-1-i];
    end
    @(posedge sclk);
    #1;
    chk("mid.busy", busy, 1'b1);
    @(negedge sclk);
    rst = 1'b1;
    #1;
    model_reset();
    check_idle("mid_rst");
    @(negedge sclk);
    rst  = 1'b0;
    cs_n = 1'b1;
    send_frame(2'd2, 9'h0C3, FRAME_W, 1'b0, 1'b0);
    do_upd();
    chk("r2.after_rst", cfg_out[2*DATA_W +: DATA_W], 9'h0C3);

    // Readback pattern from register 0.
    send_frame(2'd0, 9'h155, FRAME_W, 1'b0, 1'b0);
    do_upd();
    send_frame(2'd0, 9'h000, FRAME_W, 1'b0, 1'b0);

    // Random frames.
    for (int t = 0; t < 80; t++) begin
      ra  = ADDR_W'($urandom_range(NSLOT - 1));
      rd  = DATA_W'($urandom);
      sel = $urandom_range(3);
      if (sel == 0)      nb = $urandom_range(FRAME_W - 1, 1);
      else if (sel == 3) nb = $urandom_range(FRAME_W + 4, FRAME_W + 1);
      else               nb = FRAME_W;
      ul = 1'($urandom_range(1));
      ce = 1'($urandom_range(1));
      send_frame(ra, rd, nb, ul, ce);
      case ($urandom_range(3))
        0:       do_upd();
        1:       do_clr();
        default: ;
      endcase
    end
    do_upd();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
